// File: rtl/instruction_encoder_pkg.sv
// Shared instruction-word definitions: format codes, FSM states and field bit positions.
// The decoder imports the same package so both ends agree on where each field lives.
package instruction_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_DK_K = 2'd0,
    FMT_DK_D = 2'd1,
    FMT_S_K  = 2'd2,
    FMT_S_D  = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int WORD_W   = 16;
  localparam int OP_DK_HI = 15;
  localparam int OP_DK_LO = 8;
  localparam int OP_S_HI  = 15;
  localparam int OP_S_LO  = 12;
  localparam int S_HI     = 11;
  localparam int S_LO     = 8;
  localparam int ARP_BIT  = 7;
  localparam int D_HI     = 6;
  localparam int D_LO     = 0;
  localparam int K_HI     = 7;
  localparam int K_LO     = 0;

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// Combinational packer: format code plus instruction fields -> one 16-bit instruction word.
// Fields that the selected format does not use never reach the output.
module instr_pack
  import instruction_encoder_pkg::*;
(
  input  logic [1:0]        fmt,
  input  logic [7:0]        op,
  input  logic [3:0]        s,
  input  logic [6:0]        d,
  input  logic              arp,
  input  logic [7:0]        k,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    // NOTE: defaulting the output before the case keeps every path assigned, so no latch is inferred.
    word = '0;
    case (fmt_e'(fmt))
      FMT_DK_K: begin
        word[OP_DK_HI:OP_DK_LO] = op;
        word[K_HI:K_LO]         = k;
      end
      FMT_DK_D: begin
        word[OP_DK_HI:OP_DK_LO] = op;
        word[ARP_BIT]           = arp;
        word[D_HI:D_LO]         = d;
      end
      FMT_S_K: begin
        word[OP_S_HI:OP_S_LO] = op[7:4];
        word[S_HI:S_LO]       = s;
        word[K_HI:K_LO]       = k;
      end
      FMT_S_D: begin
        word[OP_S_HI:OP_S_LO] = op[7:4];
        word[S_HI:S_LO]       = s;
        word[ARP_BIT]         = arp;
        word[D_HI:D_LO]       = d;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Burst instruction encoder: accepts field requests and writes packed words to program
// memory at consecutive, wrapping addresses, one registered write per accepted request.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [7:0]        op,
  input  logic [3:0]        s,
  input  logic [6:0]        d,
  input  logic              arp,
  input  logic [7:0]        k,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_drop
);

  state_e              state;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   remaining;
  logic [WORD_W-1:0]   word;
  logic                accept;

  instr_pack u_pack (
    .fmt  (fmt),
    .op   (op),
    .s    (s),
    .d    (d),
    .arp  (arp),
    .k    (k),
    .word (word)
  );

  assign in_ready = (state == ST_RUN);
  assign busy     = (state == ST_RUN) || (state == ST_FLUSH);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the async reset clears every register, including the write register, so a pending write is dropped.
    if (reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      mem_we <= accept;
      done   <= 1'b0;

      if (accept) begin
        mem_addr  <= addr;
        mem_wdata <= word;
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            err_drop  <= 1'b0;
            addr      <= base_addr;
            remaining <= length;
            if (length == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end else if (in_valid) begin
            err_drop <= 1'b1;
          end
        end
        ST_RUN: begin
          // The accept that consumes the last word ends the burst; in_ready falls with it.
          if (accept && remaining == ADDR_W'(1)) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: encodings, burst timing, wrap, empty bursts,
// ignored restarts, reset mid-burst and the sticky drop error.
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] length = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        fmt = 2'd0;
  logic [7:0]        op = '0;
  logic [3:0]        s = '0;
  logic [6:0]        d = '0;
  logic              arp = 1'b0;
  logic [7:0]        k = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err_drop;

  int vectors = 0;
  int miscompares = 0;

  instruction_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .op        (op),
    .s         (s),
    .d         (d),
    .arp       (arp),
    .k         (k),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input fmt_e f, input logic [7:0] o, input logic [3:0] sv,
                     input logic [6:0] dv, input logic av, input logic [7:0] kv);
    in_valid = 1'b1;
    fmt = f;
    op = o;
    s = sv;
    d = dv;
    arp = av;
    k = kv;
  endtask

  task automatic begin_burst(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
    start = 1'b1;
    base_addr = base;
    length = len;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check("rst_we",    16'(mem_we),    16'h0);
    check("rst_addr",  16'(mem_addr),  16'h0);
    check("rst_data",  mem_wdata,      16'h0);
    check("rst_busy",  16'(busy),      16'h0);
    check("rst_ready", 16'(in_ready),  16'h0);
    check("rst_done",  16'(done),      16'h0);
    check("rst_err",   16'(err_drop),  16'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // 1: single DK_K word
    begin_burst(8'h00, 8'd1);
    check("t1_busy",  16'(busy),     16'h1);
    check("t1_ready", 16'(in_ready), 16'h1);
    check("t1_we0",   16'(mem_we),   16'h0);
    req(FMT_DK_K, 8'h2B, 4'h0, 7'h00, 1'b0, 8'hAD);
    tick();
    in_valid = 1'b0;
    check("t1_we",    16'(mem_we),   16'h1);
    check("t1_addr",  16'(mem_addr), 16'h00);
    check("t1_data",  mem_wdata,     16'h2BAD);
    check("t1_ready_low", 16'(in_ready), 16'h0);
    check("t1_done0", 16'(done),     16'h0);
    tick();
    check("t1_done",  16'(done),     16'h1);
    check("t1_we_off", 16'(mem_we),  16'h0);
    check("t1_busy_off", 16'(busy),  16'h0);
    tick();
    check("t1_done_end", 16'(done),  16'h0);

    // 2: S_D with junk in op[3:0] and k
    begin_burst(8'h10, 8'd1);
    req(FMT_S_D, 8'h27, 4'hB, 7'h2D, 1'b1, 8'hFF);
    tick();
    in_valid = 1'b0;
    check("t2_addr",  16'(mem_addr),  16'h10);
    check("t2_data",  mem_wdata,      16'h2BAD);
    check("t2_op_dk", 16'(mem_wdata[15:8]),  16'h2B);
    check("t2_op_s",  16'(mem_wdata[15:12]), 16'h2);
    check("t2_s",     16'(mem_wdata[11:8]),  16'hB);
    check("t2_d",     16'(mem_wdata[6:0]),   16'h2D);
    check("t2_k",     16'(mem_wdata[7:0]),   16'hAD);
    check("t2_arp",   16'(mem_wdata[7]),     16'h1);
    tick();
    tick();

    // 3: three-word burst wrapping FE, FF, 00
    begin_burst(8'hFE, 8'd3);
    req(FMT_DK_D, 8'h12, 4'hF, 7'h34, 1'b0, 8'hEE);
    tick();
    check("t3_we0",   16'(mem_we),   16'h1);
    check("t3_addr0", 16'(mem_addr), 16'hFE);
    check("t3_data0", mem_wdata,     16'h1234);
    check("t3_rdy0",  16'(in_ready), 16'h1);
    req(FMT_S_K, 8'h5F, 4'h6, 7'h7F, 1'b1, 8'h78);
    tick();
    check("t3_we1",   16'(mem_we),   16'h1);
    check("t3_addr1", 16'(mem_addr), 16'hFF);
    check("t3_data1", mem_wdata,     16'h5678);
    check("t3_rdy1",  16'(in_ready), 16'h1);
    req(FMT_DK_K, 8'h9A, 4'h1, 7'h55, 1'b1, 8'hBC);
    tick();
    check("t3_we2",   16'(mem_we),   16'h1);
    check("t3_addr2", 16'(mem_addr), 16'h00);
    check("t3_data2", mem_wdata,     16'h9ABC);
    check("t3_rdy2",  16'(in_ready), 16'h0);
    check("t3_busy2", 16'(busy),     16'h1);
    tick();
    in_valid = 1'b0;
    check("t3_we3",   16'(mem_we),   16'h0);
    check("t3_done",  16'(done),     16'h1);
    tick();

    // 4: empty burst, then a restart attempt during RUN
    begin_burst(8'h40, 8'd0);
    check("t4_done",  16'(done),     16'h1);
    check("t4_we",    16'(mem_we),   16'h0);
    check("t4_busy",  16'(busy),     16'h0);
    tick();
    check("t4_done_end", 16'(done),  16'h0);
    check("t4_we_end",   16'(mem_we), 16'h0);
    begin_burst(8'h50, 8'd2);
    start = 1'b1;
    base_addr = 8'h80;
    length = 8'd5;
    req(FMT_DK_K, 8'h11, 4'h0, 7'h00, 1'b0, 8'h22);
    tick();
    start = 1'b0;
    check("t4_addr0", 16'(mem_addr), 16'h50);
    check("t4_data0", mem_wdata,     16'h1122);
    req(FMT_DK_K, 8'h33, 4'h0, 7'h00, 1'b0, 8'h44);
    tick();
    in_valid = 1'b0;
    check("t4_addr1", 16'(mem_addr), 16'h51);
    check("t4_data1", mem_wdata,     16'h3344);
    check("t4_rdy1",  16'(in_ready), 16'h0);
    tick();
    check("t4_done2", 16'(done),     16'h1);
    tick();

    // 5: reset after 2 of 4 accepts
    begin_burst(8'h20, 8'd4);
    req(FMT_DK_K, 8'hAA, 4'h0, 7'h00, 1'b0, 8'hAA);
    tick();
    req(FMT_DK_K, 8'hBB, 4'h0, 7'h00, 1'b0, 8'hBB);
    tick();
    check("t5_addr1", 16'(mem_addr), 16'h21);
    check("t5_data1", mem_wdata,     16'hBBBB);
    reset = 1'b1;
    #1;
    check("t5_we",    16'(mem_we),   16'h0);
    check("t5_addr",  16'(mem_addr), 16'h0);
    check("t5_data",  mem_wdata,     16'h0);
    check("t5_busy",  16'(busy),     16'h0);
    check("t5_ready", 16'(in_ready), 16'h0);
    tick();
    check("t5_we_hold", 16'(mem_we), 16'h0);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("t5_we_after", 16'(mem_we), 16'h0);
    begin_burst(8'h60, 8'd1);
    req(FMT_DK_K, 8'hCC, 4'h0, 7'h00, 1'b0, 8'hCC);
    tick();
    in_valid = 1'b0;
    check("t5_new_addr", 16'(mem_addr), 16'h60);
    check("t5_new_data", mem_wdata,     16'hCCCC);
    tick();
    tick();

    // 6: request while idle sets the sticky error; start clears it
    req(FMT_DK_K, 8'hDE, 4'h0, 7'h00, 1'b0, 8'hAD);
    tick();
    in_valid = 1'b0;
    check("t6_err",   16'(err_drop), 16'h1);
    check("t6_we",    16'(mem_we),   16'h0);
    tick();
    check("t6_sticky", 16'(err_drop), 16'h1);
    check("t6_we2",   16'(mem_we),   16'h0);
    begin_burst(8'h00, 8'd1);
    check("t6_clear", 16'(err_drop), 16'h0);
    req(FMT_DK_K, 8'h01, 4'h0, 7'h00, 1'b0, 8'h02);
    tick();
    in_valid = 1'b0;
    check("t6_data",  mem_wdata,     16'h0102);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
